enc8b10b_multilane: RTL and testbench

Parameterised multi-lane 8b/10b encoder. It is the successor to the single-lane encoder, which needed an external disparity feedback loop. This block encodes LANES bytes per cycle and chains running disparity internally from lane 0 to lane LANES-1. It adds a valid/ready handshake, a registered output stage, and K-code legality checking. It sits between the framing logic and the serializer.

---
 rtl/enc8b10b_multilane.sv | 166 ++++++++++++++++
 tb/tb_enc8b10b_multilane.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/enc8b10b_multilane.sv
// LANES-wide 8b/10b encoder: running disparity chains lane 0 -> LANES-1, valid/ready handshake,
// registered output. Define ENC_IDLE_EN to load K28.5 idle words whenever no input is offered.
module enc8b10b_multilane #(
    parameter int LANES   = 2,
    parameter bit INIT_RD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [8*LANES-1:0]   i_data,
    input  logic [LANES-1:0]     i_kin,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [10*LANES-1:0]  o_en_data,
    output logic [LANES-1:0]     o_kerr,
    output logic                 o_rdisp
);

    // {RD- code, RD+ code}, abcdei with a at the MSB
    function automatic logic [11:0] tbl6(input logic [4:0] x);
        case (x)
            5'd0:    return {6'b100111, 6'b011000};
            5'd1:    return {6'b011101, 6'b100010};
            5'd2:    return {6'b101101, 6'b010010};
            5'd3:    return {6'b110001, 6'b110001};
            5'd4:    return {6'b110101, 6'b001010};
            5'd5:    return {6'b101001, 6'b101001};
            5'd6:    return {6'b011001, 6'b011001};
            5'd7:    return {6'b111000, 6'b000111};
            5'd8:    return {6'b111001, 6'b000110};
            5'd9:    return {6'b100101, 6'b100101};
            5'd10:   return {6'b010101, 6'b010101};
            5'd11:   return {6'b110100, 6'b110100};
            5'd12:   return {6'b001101, 6'b001101};
            5'd13:   return {6'b101100, 6'b101100};
            5'd14:   return {6'b011100, 6'b011100};
            5'd15:   return {6'b010111, 6'b101000};
            5'd16:   return {6'b011011, 6'b100100};
            5'd17:   return {6'b100011, 6'b100011};
            5'd18:   return {6'b010011, 6'b010011};
            5'd19:   return {6'b110010, 6'b110010};
            5'd20:   return {6'b001011, 6'b001011};
            5'd21:   return {6'b101010, 6'b101010};
            5'd22:   return {6'b011010, 6'b011010};
            5'd23:   return {6'b111010, 6'b000101};
            5'd24:   return {6'b110011, 6'b001100};
            5'd25:   return {6'b100110, 6'b100110};
            5'd26:   return {6'b010110, 6'b010110};
            5'd27:   return {6'b110110, 6'b001001};
            5'd28:   return {6'b001110, 6'b001110};
            5'd29:   return {6'b101110, 6'b010001};
            5'd30:   return {6'b011110, 6'b100001};
            default: return {6'b101011, 6'b010100};
        endcase
    endfunction

    // {RD- code, RD+ code}, fghj with f at the MSB
    function automatic logic [7:0] tbl4d(input logic [2:0] y, input logic a7);
        if (a7) return {4'b0111, 4'b1000};
        case (y)
            3'd0:    return {4'b1011, 4'b0100};
            3'd1:    return {4'b1001, 4'b1001};
            3'd2:    return {4'b0101, 4'b0101};
            3'd3:    return {4'b1100, 4'b0011};
            3'd4:    return {4'b1101, 4'b0010};
            3'd5:    return {4'b1010, 4'b1010};
            3'd6:    return {4'b0110, 4'b0110};
            default: return {4'b1110, 4'b0001};
        endcase
    endfunction

    function automatic logic [7:0] tbl4k(input logic [2:0] y);
        case (y)
            3'd0:    return {4'b1011, 4'b0100};
            3'd1:    return {4'b0110, 4'b1001};
            3'd2:    return {4'b1010, 4'b0101};
            3'd3:    return {4'b1100, 4'b0011};
            3'd4:    return {4'b1101, 4'b0010};
            3'd5:    return {4'b0101, 4'b1010};
            3'd6:    return {4'b1001, 4'b0110};
            default: return {4'b0111, 4'b1000};
        endcase
    endfunction

    function automatic logic k_legal(input logic [7:0] b);
        return (b[4:0] == 5'd28) ||
               ((b[7:5] == 3'd7) && (b[4:0] == 5'd23 || b[4:0] == 5'd27 ||
                                     b[4:0] == 5'd29 || b[4:0] == 5'd30));
    endfunction

    // Returns {kerr, rd_out, symbol[9:0]}; an unbalanced sub-block always flips RD.
    function automatic logic [11:0] enc_byte(input logic [7:0] b, input logic k, input logic rd);
        logic       err, rd6, a7;
        logic [7:0] bb, p4;
        logic [11:0] p6;
        logic [5:0] c6;
        logic [3:0] c4;
        err = k & ~k_legal(b);
        bb  = err ? 8'hBC : b;
        p6  = (k && bb[4:0] == 5'd28) ? {6'b001111, 6'b110000} : tbl6(bb[4:0]);
        c6  = rd ? p6[5:0] : p6[11:6];
        rd6 = rd ^ ($countones(c6) != 3);
        a7  = (bb[7:5] == 3'd7) &&
              (rd6 ? (bb[4:0] == 5'd11 || bb[4:0] == 5'd13 || bb[4:0] == 5'd14)
                   : (bb[4:0] == 5'd17 || bb[4:0] == 5'd18 || bb[4:0] == 5'd20));
        p4  = k ? tbl4k(bb[7:5]) : tbl4d(bb[7:5], a7);
        c4  = rd6 ? p4[3:0] : p4[7:4];
        return {err, rd6 ^ ($countones(c4) != 2), c6, c4};
    endfunction

    logic                valid_q, rd_q, rd_d, rd_v, load;
    logic [10*LANES-1:0] data_q, enc_d;
    logic [LANES-1:0]    kerr_q, kerr_d, src_kin;
    logic [8*LANES-1:0]  src_data;
    logic [11:0]         res;

    assign o_ready = ~valid_q | i_ready;

`ifdef ENC_IDLE_EN
    assign load     = o_ready;
    assign src_data = i_valid ? i_data : {LANES{8'hBC}};
    assign src_kin  = i_valid ? i_kin : {LANES{1'b1}};
`else
    assign load     = o_ready & i_valid;
    assign src_data = i_data;
    assign src_kin  = i_kin;
`endif

    always_comb begin
        rd_v   = rd_q;
        enc_d  = '0;
        kerr_d = '0;
        res    = '0;
        for (int n = 0; n < LANES; n++) begin
            res               = enc_byte(src_data[8*n +: 8], src_kin[n], rd_v);
            enc_d[10*n +: 10] = res[9:0];
            kerr_d[n]         = res[11];
            rd_v              = res[10];
        end
        rd_d = rd_v;
    end

    // Output register; RD advances only when a word is loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            kerr_q  <= '0;
            rd_q    <= INIT_RD;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= enc_d;
            kerr_q  <= kerr_d;
            rd_q    <= rd_d;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid   = valid_q;
    assign o_en_data = data_q;
    assign o_kerr    = kerr_q;
    assign o_rdisp   = rd_q;

endmodule

// File: tb/tb_enc8b10b_multilane.sv
// Bench for enc8b10b_multilane: rule-based 8b/10b reference model compared every cycle,
// hand-computed literal cases, then randomized handshake/data traffic.
module tb_enc8b10b_multilane;
    localparam int LANES   = 2;
    localparam bit INIT_RD = 1'b0;
`ifdef ENC_IDLE_EN
    localparam bit IDLE = 1'b1;
`else
    localparam bit IDLE = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_ready = 1'b0;
    logic [15:0] i_data = '0;
    logic [1:0]  i_kin = '0;
    logic        o_ready, o_valid, o_rdisp;
    logic [19:0] o_en_data;
    logic [1:0]  o_kerr;

    enc8b10b_multilane #(.LANES(LANES), .INIT_RD(INIT_RD)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .i_kin(i_kin), .o_valid(o_valid), .i_ready(i_ready), .o_en_data(o_en_data),
        .o_kerr(o_kerr), .o_rdisp(o_rdisp)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // RD- columns only; the RD+ code is derived by complementing where the rules demand it
    logic [5:0] N6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                            6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                            6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                            6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                            6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                            6'b011110, 6'b101011};
    logic [3:0] ND4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] NK4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    logic [7:0] KL [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                            8'hF7, 8'hFB, 8'hFD, 8'hFE};

    function automatic logic upd(input logic rd, input int ones, input int width);
        if (2*ones > width) return 1'b1;
        if (2*ones < width) return 1'b0;
        return rd;
    endfunction

    function automatic logic [11:0] m_enc(input logic [7:0] b, input logic k, input logic rd);
        int x, y;
        logic err, r;
        logic [5:0] c6;
        logic [3:0] c4;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        err = k && !(x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
        if (err) begin x = 28; y = 5; end
        c6 = (k && x == 28) ? 6'b001111 : N6[x];
        if (rd && ($countones(c6) != 3 || (!k && x == 7))) c6 = ~c6;
        r = upd(rd, $countones(c6), 6);
        if (k) c4 = NK4[y];
        else if (y == 7 && ((!r && (x == 17 || x == 18 || x == 20)) ||
                            (r && (x == 11 || x == 13 || x == 14)))) c4 = 4'b0111;
        else c4 = ND4[y];
        if (r && (k || $countones(c4) != 2 || y == 3)) c4 = ~c4;
        return {err, upd(r, $countones(c4), 4), c6, c4};
    endfunction

    function automatic logic [11*LANES:0] m_word(input logic [8*LANES-1:0] d,
                                                 input logic [LANES-1:0] k, input logic rd);
        logic [10*LANES-1:0] dat;
        logic [LANES-1:0]    ke;
        logic                r;
        logic [11:0]         e;
        r = rd; dat = '0; ke = '0;
        for (int n = 0; n < LANES; n++) begin
            e = m_enc(d[8*n +: 8], k[n], r);
            dat[10*n +: 10] = e[9:0];
            ke[n] = e[11];
            r = e[10];
        end
        return {ke, r, dat};
    endfunction

    logic        m_valid, m_rd;
    logic [19:0] m_data;
    logic [1:0]  m_kerr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_rd <= INIT_RD; m_data <= '0; m_kerr <= '0;
        end else if ((!m_valid || i_ready) && (i_valid || IDLE)) begin
            {m_kerr, m_rd, m_data} <= m_word(i_valid ? i_data : {LANES{8'hBC}},
                                             i_valid ? i_kin : {LANES{1'b1}}, m_rd);
            m_valid <= 1'b1;
        end else if (i_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("o_valid", o_valid, m_valid);
        check("o_ready", o_ready, !m_valid || i_ready);
        check("o_rdisp", o_rdisp, m_rd);
        if (m_valid) begin
            check("o_en_data", o_en_data, m_data);
            check("o_kerr", o_kerr, m_kerr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] k);
        i_valid = 1'b1; i_data = d; i_kin = k; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] b;
        logic [1:0] k;
        logic [15:0] d;
        rst = 1'b1;
        tick();
        check("rst_valid", o_valid, 1'b0);
        check("rst_data", o_en_data, 20'h0);
        check("rst_kerr", o_kerr, 2'b00);
        check("rst_rdisp", o_rdisp, INIT_RD);
        rst = 1'b0;

        send(16'h0000, 2'b00);
        check("d00_lane0", o_en_data[9:0], 10'b1001110100);
        check("d00_lane1", o_en_data[19:10], 10'b1001110100);
        check("d00_rdisp", o_rdisp, 1'b0);

        do_reset();
        send(16'hBCBC, 2'b11);
        check("k285_lane0", o_en_data[9:0], 10'b0011111010);
        check("k285_lane1", o_en_data[19:10], 10'b1100000101);
        check("k285_rdisp", o_rdisp, 1'b0);
        check("k285_kerr", o_kerr, 2'b00);

        do_reset();
        send(16'hB523, 2'b00);
        check("d31_lane0", o_en_data[9:0], 10'b1100011001);
        check("d215_lane1", o_en_data[19:10], 10'b1010101010);
        check("d31_rdisp", o_rdisp, 1'b0);

        do_reset();
        send(16'h00F1, 2'b00);
        check("a7_lane0", o_en_data[9:0], 10'b1000110111);
        check("a7_lane1", o_en_data[19:10], 10'b0110001011);
        check("a7_rdisp", o_rdisp, 1'b1);

        do_reset();
        send(16'h0000, 2'b01);
        check("kerr_flag", o_kerr, 2'b01);
        check("kerr_lane0", o_en_data[9:0], 10'b0011111010);
        check("kerr_lane1", o_en_data[19:10], 10'b0110001011);

        do_reset();
        send(16'h00BC, 2'b01);
        i_valid = 1'b1; i_data = 16'h0000; i_kin = 2'b00; i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_ready", o_ready, 1'b0);
            check("stall_valid", o_valid, 1'b1);
            check("stall_data", o_en_data, {10'b0110001011, 10'b0011111010});
            check("stall_rdisp", o_rdisp, 1'b1);
        end
        i_ready = 1'b1;
        tick();
        check("post_stall_data", o_en_data, {10'b0110001011, 10'b0110001011});
        check("post_stall_rdisp", o_rdisp, 1'b1);
        i_ready = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_rdisp", o_rdisp, INIT_RD);
        check("midrst_data", o_en_data, 20'h0);
        i_valid = 1'b0;
        tick();
        rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < LANES; n++) begin
                k[n] = ($urandom_range(3) == 0);
                if (k[n] && $urandom_range(9) < 7) b = KL[$urandom_range(11)];
                else b = 8'($urandom);
                d[8*n +: 8] = b;
            end
            i_data = d; i_kin = k;
            i_valid = ($urandom_range(9) < 7);
            i_ready = ($urandom_range(9) < 7);
            if (c == 1500) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        i_valid = 1'b0; i_ready = 1'b1;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
